blockram_initiator: RTL and testbench

//  Requester-side adapter that drives one port of a synchronous NO_CHANGE

---
 rtl/blockram_initiator.sv | 90 +++++++++
 tb/tb_blockram_initiator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/blockram_initiator.sv
// Requester-side adapter: valid/ready request channel to one NO_CHANGE block RAM port,
// returning one in-order response per request with a single outstanding slot.
module blockram_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH/8-1:0]       req_wstrb,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          bram_en,
  output logic                          bram_rst,
  output logic [DATA_WIDTH/8-1:0]       bram_we,
  output logic [$clog2(DATA_DEPTH)-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int RAM_AW = $clog2(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DATA_DEPTH);

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  accept;
  logic                  rsp_read;

  assign word_idx = req_addr >> OFF_W;
  assign in_range = (word_idx < DEPTH_LIMIT);

  // Request handshake and RAM port drive; the RAM sees only accepted in-range requests.
  always_comb begin
    req_ready = 1'b1;
    accept    = 1'b0;
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_rst  = 1'b0;
    bram_addr = word_idx[RAM_AW-1:0];
    bram_din  = req_wdata;
    if (rsp_valid && !rsp_ready) begin
      req_ready = 1'b0;
    end else begin
      req_ready = 1'b1;
    end
    accept = req_valid && req_ready;
    if (accept && in_range) begin
      bram_en = 1'b1;
      bram_we = req_wstrb;
    end else begin
      bram_en = 1'b0;
      bram_we = '0;
    end
  end

  // Response slot: loads on accept, drains on consume, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_read  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_read  <= (req_wstrb == {STRB_W{1'b0}});
      rsp_err   <= !in_range;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

  // NO_CHANGE RAM holds its output while stalled, so read data passes straight through.
  always_comb begin
    if (rsp_valid && rsp_read && !rsp_err) begin
      rsp_rdata = bram_dout;
    end else begin
      rsp_rdata = '0;
    end
  end

endmodule

// File: tb/tb_blockram_initiator.sv
// Randomized and directed bench for blockram_initiator against a response-level
// reference model (byte-merged memory image plus an expected-response queue).
module tb_blockram_initiator;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [3:0]      req_wstrb;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            bram_en;
  logic            bram_rst;
  logic [3:0]      bram_we;
  logic [9:0]      bram_addr;
  logic [DW-1:0]   bram_din;
  logic [DW-1:0]   ram_dout;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] ram     [0:DEPTH-1];

  blockram_initiator #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bram_en(bram_en), .bram_rst(bram_rst), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // NO_CHANGE block RAM: output updates only on enabled reads.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) ram[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
      end else begin
        ram_dout <= ram[bram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check all outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic rr);
    logic        exp_ready, acc, inr, busy;
    logic [31:0] idx;
    rsp_t        r;
    req_valid = v; req_addr = a; req_wstrb = s; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    busy      = (exp_q.size() != 0);
    exp_ready = !busy || rr;
    acc       = v && exp_ready;
    idx       = a / 4;
    inr       = (idx < DEPTH);
    check("req_ready", req_ready, exp_ready);
    check("bram_en", bram_en, acc && inr);
    check("bram_we", bram_we, (acc && inr) ? s : 4'h0);
    check("bram_rst", bram_rst, 1'b0);
    if (acc && inr) begin
      check("bram_addr", bram_addr, idx % DEPTH);
      check("bram_din", bram_din, d);
    end
    check("rsp_valid", rsp_valid, busy);
    check("rsp_rdata", rsp_rdata, busy ? exp_q[0].rdata : 32'h0);
    if (busy) check("rsp_err", rsp_err, exp_q[0].err);
    @(posedge clk);
    if (busy && rr) void'(exp_q.pop_front());
    if (acc) begin
      r.err   = !inr;
      r.rdata = (inr && s == 4'h0) ? ref_mem[idx] : 32'h0;
      if (inr)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      exp_q.push_back(r);
    end
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram_dout = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wstrb = 4'h0;
    req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_bram_en_idle", bram_en, 1'b0);
    req_valid = 1'b1; req_addr = 32'h20;
    #1;
    check("rst_bram_en_req", bram_en, 1'b1);
    req_valid = 1'b0;
    #1;
    reset = 1'b0;

    // Full write, then read back on the next cycle.
    step(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
    step(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
    // Single-byte merge.
    step(1'b1, 32'h10, 4'h2, 32'h0000AB00, 1'b1);
    step(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
    // Back-to-back reads at full rate.
    step(1'b1, 32'h0, 4'h0, 32'h0, 1'b1);
    step(1'b1, 32'h4, 4'h0, 32'h0, 1'b1);
    step(1'b1, 32'h8, 4'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    // Stall for three cycles with a request waiting.
    step(1'b1, 32'h4, 4'h0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 32'hC, 4'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    // Out-of-range read and write; word 2 alias must stay untouched.
    step(1'b1, DEPTH * 4, 4'h0, 32'h0, 1'b1);
    step(1'b1, DEPTH * 4 + 8, 4'hF, 32'h12345678, 1'b1);
    step(1'b1, 32'h8, 4'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);

    // Asynchronous reset while a response is pending.
    step(1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rsp_valid", rsp_valid, 1'b0);
    check("async_req_ready", req_ready, 1'b1);
    check("async_bram_en", bram_en, 1'b0);
    exp_q.delete();
    reset = 1'b0;
    step(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(0, DEPTH + 15) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      d = $urandom;
      step($urandom_range(0, 9) < 7, a, s, d, $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 4 && exp_q.size() != 0; n++)
      step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    check("drain", exp_q.size(), 0);

    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== ref_mem[i]) check("ram_image", ram[i], ref_mem[i]);
    check("ram_word_2", ram[2], ref_mem[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
